// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter with prescaler, parallel Gray load, wrap/stop terminal mode.
// Define GRAY_CNT_UPDOWN_EN to add the Up port and down-counting logic.
module gray_counter_n #(
   parameter int WIDTH = 3,
   parameter int DIV   = 1,
   parameter int WRAP  = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clr,
   input  logic             En,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadGray,
`ifdef GRAY_CNT_UPDOWN_EN
   input  logic             Up,
`endif
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] Bin,
   output logic             Tc,
   output logic             Overflow
);

   logic             step;
   logic             at_term;
   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] load_bin;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign load_bin = gray2bin(LoadGray);

   // Prescaler: a step qualifies on the DIV-th enabled cycle since the last step, load or clear.
   generate
      if (DIV == 1) begin : g_no_pre
         assign step = En;
      end else begin : g_pre
         localparam int PW = $clog2(DIV);
         logic [PW-1:0] pre;

         assign step = En && (pre == PW'(DIV - 1));

         always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
               pre <= '0;
            end else if (Clr || Load) begin
               pre <= '0;
            end else if (En) begin
               pre <= step ? '0 : pre + PW'(1);
            end
         end
      end
   endgenerate

   always_comb begin
      at_term  = 1'b0;
      bin_next = Bin;
`ifdef GRAY_CNT_UPDOWN_EN
      if (!Up) begin
         at_term  = (Bin == '0);
         bin_next = at_term ? ((WRAP != 0) ? '1 : Bin) : Bin - WIDTH'(1);
      end else begin
         at_term  = (Bin == '1);
         bin_next = at_term ? ((WRAP != 0) ? '0 : Bin) : Bin + WIDTH'(1);
      end
`else
      at_term  = (Bin == '1);
      bin_next = at_term ? ((WRAP != 0) ? '0 : Bin) : Bin + WIDTH'(1);
`endif
   end

   // Output is recomputed from the same next value as Bin so the two never skew.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Bin      <= '0;
         Output   <= '0;
         Tc       <= 1'b0;
         Overflow <= 1'b0;
      end else if (Clr) begin
         Bin      <= '0;
         Output   <= '0;
         Tc       <= 1'b0;
         Overflow <= 1'b0;
      end else if (Load) begin
         Bin    <= load_bin;
         Output <= LoadGray;
         Tc     <= 1'b0;
      end else if (step) begin
         Bin    <= bin_next;
         Output <= bin_next ^ (bin_next >> 1);
         Tc     <= at_term;
         if (at_term) begin
            Overflow <= 1'b1;
         end
      end else begin
         Tc <= 1'b0;
      end
   end

endmodule
